// File: rtl/blur_window_sequencer.sv
// -----------------------------------------------------------------------------
// blur_window_sequencer
//
// Frame-level controller in front of a KxK gaussian blur core. It accepts a
// raster pixel stream, keeps KERNEL_SIZE-1 previous lines in line buffers and
// builds the KxK window for every accepted pixel. It also re-times the core's
// result into a framed output stream. Only the valid convolution region,
// (W-K+1) x (H-K+1) pixels, is flagged on the output.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   cfg_width, cfg_height  frame size, sampled when start is honoured in IDLE
//   start                  begin a frame (ignored unless IDLE)
//   busy                   high while a frame is in RUN or DRAIN
//   done                   1-cycle pulse on return to IDLE after out_last
//   cfg_err                1-cycle pulse after a start with an illegal size
//   in_valid/in_ready      pixel input handshake; in_pixel is row-major
//   win_data/win_valid     window to the core; [0][0] is the oldest row/col
//   core_pixel             core result, CORE_LATENCY cycles after win_data
//   out_valid/out_last     framed output; out_pixel is core_pixel passthrough
// -----------------------------------------------------------------------------
module blur_window_sequencer #(
    parameter int PIXEL_DEPTH  = 8,
    parameter int KERNEL_SIZE  = 7,
    parameter int MAX_WIDTH    = 640,
    parameter int MAX_HEIGHT   = 480,
    parameter int CORE_LATENCY = 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]                         cfg_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0]                        cfg_height,
    input  logic                                                   start,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   cfg_err,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [PIXEL_DEPTH-1:0]                                 in_pixel,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_DEPTH-1:0] win_data,
    output logic                                                   win_valid,
    input  logic [PIXEL_DEPTH-1:0]                                 core_pixel,
    output logic                                                   out_valid,
    output logic [PIXEL_DEPTH-1:0]                                 out_pixel,
    output logic                                                   out_last
);

    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int HW = $clog2(MAX_HEIGHT + 1);

    localparam logic [WW-1:0] K_W     = WW'(KERNEL_SIZE);
    localparam logic [HW-1:0] K_H     = HW'(KERNEL_SIZE);
    localparam logic [WW-1:0] KM1_W   = WW'(KERNEL_SIZE - 1);
    localparam logic [HW-1:0] KM1_H   = HW'(KERNEL_SIZE - 1);
    localparam logic [WW-1:0] MAX_W_W = WW'(MAX_WIDTH);
    localparam logic [HW-1:0] MAX_H_H = HW'(MAX_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_DEPTH-1:0] window_t;

    state_t                  state_q, state_d;
    logic [WW-1:0]           width_q, width_d;
    logic [HW-1:0]           height_q, height_d;
    logic [WW-1:0]           col_q, col_d;
    logic [HW-1:0]           row_q, row_d;
    window_t                 win_q, win_d;
    logic                    win_valid_q, win_valid_d;
    logic                    win_last_q, win_last_d;
    logic [CORE_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [CORE_LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic                    done_q, done_d;
    logic                    cfg_err_q, cfg_err_d;

    // Line buffer 0 holds the oldest stored row, KERNEL_SIZE-2 the newest.
    logic [PIXEL_DEPTH-1:0]  line_buf [KERNEL_SIZE-1][MAX_WIDTH];

    logic cfg_ok;
    logic xfer;
    logic last_col;
    logic last_row;

    assign cfg_ok   = (cfg_width  >= K_W) && (cfg_width  <= MAX_W_W) &&
                      (cfg_height >= K_H) && (cfg_height <= MAX_H_H);
    assign in_ready = (state_q == S_RUN);
    assign xfer     = in_valid && in_ready;
    assign last_col = (col_q == width_q - WW'(1));
    assign last_row = (row_q == height_q - HW'(1));

    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = S_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (xfer) begin
                    // Shift columns left; the new rightmost column is the
                    // stored rows at this column plus the incoming pixel.
                    for (int i = 0; i < KERNEL_SIZE; i++) begin
                        for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                            win_d[i][j] = win_q[i][j+1];
                        end
                    end
                    for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
                        win_d[i][KERNEL_SIZE-1] = line_buf[i][col_q];
                    end
                    win_d[KERNEL_SIZE-1][KERNEL_SIZE-1] = in_pixel;

                    // Columns below K-1 still hold the previous row's tail.
                    win_valid_d = (row_q >= KM1_H) && (col_q >= KM1_W);

                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d      = '0;
                            win_last_d = 1'b1;
                            state_d    = S_DRAIN;
                        end else begin
                            row_d = row_q + HW'(1);
                        end
                    end else begin
                        col_d = col_q + WW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid and last flags travel alongside the core's internal latency.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = win_valid_q;
        last_pipe_d[0] = win_last_q;
        for (int i = 1; i < CORE_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // NOTE: the line buffers are RAMs and are deliberately not reset; every
    // location is rewritten in a frame before the window can read it.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int i = 0; i < KERNEL_SIZE - 2; i++) begin
                line_buf[i][col_q] <= line_buf[i+1][col_q];
            end
            line_buf[KERNEL_SIZE-2][col_q] <= in_pixel;
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign win_data  = win_q;
    assign win_valid = win_valid_q;
    assign out_valid = vld_pipe_q[CORE_LATENCY-1];
    assign out_last  = last_pipe_q[CORE_LATENCY-1];
    assign out_pixel = core_pixel;

endmodule

// File: tb/tb_blur_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_blur_window_sequencer
//
// Randomised and directed bench for blur_window_sequencer. The bench stands in
// for a registered blur core (position-weighted sum of the window). A reference
// model stores every accepted pixel in a full frame array and derives the
// expected window, flags and core output from raster coordinates.
// -----------------------------------------------------------------------------
module tb_blur_window_sequencer;

    localparam int K    = 7;
    localparam int PD   = 8;
    localparam int MAXW = 640;
    localparam int MAXH = 480;

    typedef logic [K-1:0][K-1:0][PD-1:0] window_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    cfg_width;
    logic [8:0]    cfg_height;
    logic          start;
    logic          busy, done, cfg_err;
    logic          in_valid, in_ready;
    logic [PD-1:0] in_pixel;
    window_t       win_data;
    logic          win_valid;
    logic [PD-1:0] core_pixel;
    logic          out_valid, out_last;
    logic [PD-1:0] out_pixel;

    int n_checks = 0;
    int n_errors = 0;

    blur_window_sequencer #(
        .PIXEL_DEPTH (PD),
        .KERNEL_SIZE (K),
        .MAX_WIDTH   (MAXW),
        .MAX_HEIGHT  (MAXH),
        .CORE_LATENCY(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_width (cfg_width),
        .cfg_height(cfg_height),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .win_data  (win_data),
        .win_valid (win_valid),
        .core_pixel(core_pixel),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stand-in core: position-weighted sum, so swapped pixels change the result.
    function automatic logic [PD-1:0] core_fn(input window_t w);
        int s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += int'(w[i][j]) * (i * K + j + 1);
        return PD'(s);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) core_pixel <= '0;
        else     core_pixel <= core_fn(win_data);
    end

    // ---------------- reference model ----------------
    logic [PD-1:0] frame [MAXH][MAXW];
    int      mode;          // 0 idle, 1 accepting pixels, 2 draining
    int      mw, mh, mr, mc;
    bit      exp_wv, exp_wl, exp_ov, exp_ol, exp_done, exp_err;
    int      exp_wr, exp_wc;
    logic [PD-1:0] exp_op;
    window_t ew;
    int      cyc = 0, out_count = 0, last_count = 0, err_count = 0;
    int      first_xfer_cyc = 0, last_out_cyc = 0;

    always @(negedge clk) begin
        bit nx_wv, nx_wl, nx_ov, nx_ol;
        logic [PD-1:0] nx_op;
        int bad;
        cyc++;
        if (rst) begin
            mode = 0; exp_wv = 0; exp_wl = 0; exp_ov = 0; exp_ol = 0;
            exp_done = 0; exp_err = 0;
        end else begin
            check("in_ready", in_ready, mode == 1);
            check("busy", busy, mode != 0);
            check("done", done, exp_done);
            check("cfg_err", cfg_err, exp_err);
            check("win_valid", win_valid, exp_wv);
            check("out_valid", out_valid, exp_ov);
            check("out_last", out_last, exp_ov & exp_ol);
            if (exp_ov) check("out_pixel", out_pixel, exp_op);
            nx_op = '0;
            if (exp_wv) begin
                bad = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++) begin
                        ew[i][j] = frame[exp_wr-K+1+i][exp_wc-K+1+j];
                        if (win_data[i][j] !== ew[i][j]) bad++;
                    end
                check("win_data_bad_pixels", bad, 0);
                nx_op = core_fn(ew);
            end
            if (out_valid) begin out_count++; last_out_cyc = cyc; end
            if (out_last) last_count++;
            if (cfg_err) err_count++;

            nx_ov = exp_wv; nx_ol = exp_wl;
            nx_wv = 0; nx_wl = 0;
            exp_done = 0; exp_err = 0;
            case (mode)
                0: if (start) begin
                    if (cfg_width >= K && cfg_width <= MAXW &&
                        cfg_height >= K && cfg_height <= MAXH) begin
                        mode = 1; mw = int'(cfg_width); mh = int'(cfg_height);
                        mr = 0; mc = 0;
                    end else begin
                        exp_err = 1;
                    end
                end
                1: if (in_valid) begin
                    frame[mr][mc] = in_pixel;
                    if (mr == 0 && mc == 0) first_xfer_cyc = cyc;
                    nx_wv  = (mr >= K - 1) && (mc >= K - 1);
                    nx_wl  = (mr == mh - 1) && (mc == mw - 1);
                    exp_wr = mr; exp_wc = mc;
                    if (mc == mw - 1) begin
                        mc = 0;
                        if (mr == mh - 1) begin mr = 0; mode = 2; end
                        else mr++;
                    end else mc++;
                end
                default: if (exp_ov && exp_ol) begin mode = 0; exp_done = 1; end
            endcase
            exp_wv = nx_wv; exp_wl = nx_wl;
            exp_ov = nx_ov; exp_ol = nx_ol; exp_op = nx_op;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame(input int w, input int h);
        @(posedge clk); #1;
        cfg_width = 10'(w); cfg_height = 9'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // pat: 0 = all 255, 1 = column index, 2 = random
    // gap: 0 = continuous, 1 = toggle 1/0, 2 = random gaps
    task automatic feed(input int w, input int npix, input int pat, input int gap);
        int  n = 0;
        int  cycles = 0;
        bit  tog = 1'b1;
        bit  x;
        while (n < npix && cycles < npix * 4 + 100) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = tog;
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            tog = ~tog;
            case (pat)
                0:       in_pixel = 8'hff;
                1:       in_pixel = PD'(n % w);
                default: in_pixel = PD'($urandom);
            endcase
            @(negedge clk);
            x = in_valid && in_ready;
            @(posedge clk); #1;
            if (x) n++;
            cycles++;
        end
        in_valid = 1'b0;
        check("feed_accepted", n, npix);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int w, input int h, input int pat, input int gap);
        int o0 = out_count;
        int l0 = last_count;
        start_frame(w, h);
        feed(w, w * h, pat, gap);
        wait_done(20);
        check("frame_out_count", out_count - o0, (w - K + 1) * (h - K + 1));
        check("frame_last_count", last_count - l0, 1);
    endtask

    initial begin
        int o0, l0, e0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
        cfg_width = '0; cfg_height = '0;
        #23;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_win_nonzero", win_data != '0, 0);
        check("rst_out_valid", out_valid, 0);
        @(posedge clk); #2 rst = 1'b0;

        // 1) 7x7 all 255, continuous: one output 50 cycles after first transfer
        o0 = out_count;
        run_frame(7, 7, 0, 0);
        check("t1_latency", last_out_cyc - first_xfer_cyc, 50);

        // 2) 8x7 column-index pattern: two outputs, last on the second
        run_frame(8, 7, 1, 0);

        // 3) 10x10 toggling in_valid: 16 outputs
        run_frame(10, 10, 2, 1);

        // 4) illegal sizes
        e0 = err_count;
        start_frame(6, 7);
        repeat (3) @(posedge clk);
        #1 start_frame(641, 7);
        repeat (3) @(posedge clk);
        #1 start_frame(7, 481);
        repeat (3) @(posedge clk);
        #1 check("t4_cfg_err_pulses", err_count - e0, 3);
        check("t4_busy", busy, 0);

        // 5) reset at row 8 of a 640x480 frame, then a fresh 7x7 frame
        l0 = last_count;
        start_frame(640, 480);
        feed(640, 640 * 8, 2, 0);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 0);
        check("t5_win_valid", win_valid, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_last", out_last, 0);
        check("t5_out_pixel", out_pixel, 0);
        check("t5_win_nonzero", win_data != '0, 0);
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        check("t5_no_last", last_count - l0, 0);
        run_frame(7, 7, 2, 0);

        // 6) back-to-back 7x7 frames with start held high
        o0 = out_count; l0 = last_count;
        @(posedge clk); #1;
        cfg_width = 10'd7; cfg_height = 9'd7; start = 1'b1;
        feed(7, 49, 2, 0);
        wait_done(20);
        start = 1'b0;
        check("t6_busy_after_done", busy, 1);
        feed(7, 49, 2, 2);
        wait_done(20);
        check("t6_out_count", out_count - o0, 2);
        check("t6_last_count", last_count - l0, 2);

        // random frame sizes, pixels and gaps
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(7, 12), $urandom_range(7, 10), 2, $urandom_range(0, 2));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
